partoserial: RTL and testbench

Parallel-to-serial transmitter for the 8b serial link. Takes bytes over a valid/ready handshake and serializes them MSB-first at one bit per `clk_8f` cycle. It fills every word slot with no pending data with the idle/comma byte 0xBC. After reset it sends a guaranteed preamble of idle words so the far-end receiver can reach its active state. The block sits on the transmit side of the link, feeding the serial line that the receiver samples on `clk_8f` and word-aligns on `clk_f`.

---
 rtl/link_pkg.sv | 12 +
 rtl/link_phase_cnt.sv | 29 ++
 rtl/partoserial.sv | 83 ++++++++
 tb/tb_partoserial.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared constants for the 8b serial link (transmitter and receiver).
package link_pkg;

    localparam int unsigned WORD_BITS = 8;

    // Comma/idle byte carried in every slot without payload.
    localparam logic [WORD_BITS-1:0] IDLE_WORD = 8'hBC;

    // Default number of idle words guaranteed after reset.
    localparam logic [7:0] PREAMBLE_WORDS_DEFAULT = 8'd8;

endpackage

// File: rtl/link_phase_cnt.sv
// 3-bit bit-position counter for the serial link word framing.
module link_phase_cnt (
    input  logic clk_i,
    input  logic rst_ni,
    output logic word_start_o,
    output logic wrap_o
);

    logic [2:0] phase_q;
    logic [2:0] phase_d;

    // Free-running wrap counter; 7 + 1 rolls over to 0 to start a new word.
    always_comb begin
        phase_d = phase_q + 3'd1;
    end

    // Phase register; reset parks it at 7 so the first edge loads a word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 3'd7;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign word_start_o = (phase_q == 3'd0);
    assign wrap_o       = (phase_q == 3'd7);

endmodule

// File: rtl/partoserial.sv
// Parallel-to-serial link transmitter: MSB-first, idle-filled, with a
// guaranteed idle preamble after reset.
module partoserial
    import link_pkg::*;
#(
    parameter logic [WORD_BITS-1:0] IDLE_WORD      = link_pkg::IDLE_WORD,
    parameter logic [7:0]           PREAMBLE_WORDS = PREAMBLE_WORDS_DEFAULT
) (
    input  logic                 clk_8f,
    input  logic                 reset_L,
    input  logic [WORD_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 data_out,
    output logic                 word_start,
    output logic                 active_out
);

    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [7:0]           pre_cnt_q, pre_cnt_d;
    logic                 active_q, active_d;
    logic                 load;
    logic                 accept;

    link_phase_cnt u_phase (
        .clk_i        (clk_8f),
        .rst_ni       (reset_L),
        .word_start_o (word_start),
        .wrap_o       (load)
    );

    assign accept = valid_in && !hold_full_q;

    // Next-state: shift or load a word, capture handshakes, count preamble.
    // The load looks at hold_full_q as it was before this edge, so a byte
    // accepted at the load edge itself waits for the following slot.
    always_comb begin
        shift_d     = {shift_q[WORD_BITS-2:0], 1'b0};
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        pre_cnt_d   = pre_cnt_q;
        if (load) begin
            if (active_q && hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                shift_d = IDLE_WORD;
                if (pre_cnt_q < PREAMBLE_WORDS) begin
                    pre_cnt_d = pre_cnt_q + 8'd1;
                end
            end
        end
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
        active_d = active_q || (pre_cnt_d == PREAMBLE_WORDS);
    end

    // State registers; reset aborts any word and drops a pending byte.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            pre_cnt_q   <= '0;
            active_q    <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            pre_cnt_q   <= pre_cnt_d;
            active_q    <= active_d;
        end
    end

    assign data_out   = shift_q[WORD_BITS-1];
    assign ready_out  = !hold_full_q;
    assign active_out = active_q;

endmodule

// File: tb/tb_partoserial.sv
// Directed bench for partoserial: framing, preamble, handshake, reset abort.
module tb_partoserial;

    logic       clk_8f = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       word_start;
    logic       active_out;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rdy_cnt = 0;
    logic [7:0]  src[$];

    localparam logic [7:0] IDLE = 8'hBC;

    partoserial #(
        .IDLE_WORD      (8'hBC),
        .PREAMBLE_WORDS (8'd8)
    ) dut (
        .clk_8f     (clk_8f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .word_start (word_start),
        .active_out (active_out)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: offer the head of src, advance on handshake, sample at +1.
    task automatic step();
        logic acc;
        valid_in = (src.size() > 0);
        data_in  = valid_in ? src[0] : 8'h00;
        acc      = valid_in && ready_out;
        @(posedge clk_8f);
        #1;
        if (acc) void'(src.pop_front());
    endtask

    // Expect bits first..last of word w on the line, counting ready cycles.
    task automatic run_word(input string tag, input logic [7:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step();
            check({tag, "_bit"}, {7'd0, data_out}, {7'd0, w[7-i]});
            check({tag, "_ws"}, {7'd0, word_start}, {7'd0, (i == 0)});
            if (ready_out) rdy_cnt++;
        end
    endtask

    task automatic preamble(input string tag);
        for (int k = 1; k <= 8; k++) begin
            run_word(tag, IDLE, 0, 7);
            check({tag, "_active"}, {7'd0, active_out}, {7'd0, (k == 8)});
        end
    endtask

    initial begin
        // Reset values, with a handshake offered during reset
        reset_L  = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'h55;
        repeat (3) @(posedge clk_8f);
        #1;
        check("rst_data", {7'd0, data_out}, 8'd0);
        check("rst_ws", {7'd0, word_start}, 8'd0);
        check("rst_ready", {7'd0, ready_out}, 8'd1);
        check("rst_active", {7'd0, active_out}, 8'd0);

        // Idle preamble with nothing offered
        src.delete();
        valid_in = 1'b0;
        reset_L  = 1'b1;
        preamble("t1_pre");
        check("t1_ready", {7'd0, ready_out}, 8'd1);
        run_word("t1_post", IDLE, 0, 7);

        // 0xA5 offered from reset release: held through the preamble
        reset_L = 1'b0;
        #1;
        check("t2_rst_data", {7'd0, data_out}, 8'd0);
        @(posedge clk_8f);
        #1;
        src.push_back(8'hA5);
        reset_L = 1'b1;
        run_word("t2_w1", IDLE, 0, 0);
        check("t2_ready_drop", {7'd0, ready_out}, 8'd0);
        run_word("t2_w1", IDLE, 1, 7);
        for (int k = 2; k <= 8; k++) run_word("t2_pre", IDLE, 0, 7);
        check("t2_active", {7'd0, active_out}, 8'd1);
        check("t2_ready_pre", {7'd0, ready_out}, 8'd0);
        run_word("t2_data", 8'hA5, 0, 7);
        check("t2_ready_after", {7'd0, ready_out}, 8'd1);
        run_word("t2_idle", IDLE, 0, 7);

        // Byte accepted at the load edge: one idle word first
        src.push_back(8'h3C);
        rdy_cnt = 0;
        run_word("t4_slot", IDLE, 0, 7);
        check("t4_ready_slot", rdy_cnt[7:0], 8'd0);
        rdy_cnt = 0;
        run_word("t4_data", 8'h3C, 0, 7);
        check("t4_ready_data", rdy_cnt[7:0], 8'd8);

        // Back-to-back bytes with no idle gap
        src.push_back(8'h01);
        src.push_back(8'h80);
        src.push_back(8'hFF);
        rdy_cnt = 0;
        run_word("t3_slot", IDLE, 0, 7);
        check("t3_ready_slot", rdy_cnt[7:0], 8'd0);
        rdy_cnt = 0;
        run_word("t3_d01", 8'h01, 0, 7);
        check("t3_ready_d01", rdy_cnt[7:0], 8'd1);
        rdy_cnt = 0;
        run_word("t3_d80", 8'h80, 0, 7);
        check("t3_ready_d80", rdy_cnt[7:0], 8'd1);
        rdy_cnt = 0;
        run_word("t3_dFF", 8'hFF, 0, 7);
        check("t3_ready_dFF", rdy_cnt[7:0], 8'd8);
        run_word("t3_idle", IDLE, 0, 7);

        // Payload equal to the idle byte
        src.push_back(8'hBC);
        rdy_cnt = 0;
        run_word("t6_slot", IDLE, 0, 7);
        check("t6_ready_slot", rdy_cnt[7:0], 8'd0);
        rdy_cnt = 0;
        run_word("t6_data", 8'hBC, 0, 7);
        check("t6_ready_data", rdy_cnt[7:0], 8'd8);

        // Reset at phase 3 of a data word with another byte held
        src.push_back(8'h11);
        src.push_back(8'h22);
        run_word("t5_slot", IDLE, 0, 7);
        run_word("t5_d11", 8'h11, 0, 3);
        check("t5_hold_full", {7'd0, ready_out}, 8'd0);
        reset_L = 1'b0;
        #1;
        check("t5_rst_data", {7'd0, data_out}, 8'd0);
        check("t5_rst_ready", {7'd0, ready_out}, 8'd1);
        check("t5_rst_ws", {7'd0, word_start}, 8'd0);
        check("t5_rst_active", {7'd0, active_out}, 8'd0);
        src.delete();
        @(posedge clk_8f);
        #1;
        reset_L = 1'b1;
        preamble("t5_pre");
        run_word("t5_post1", IDLE, 0, 7);
        run_word("t5_post2", IDLE, 0, 7);
        check("t5_ready_end", {7'd0, ready_out}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
